// File: rtl/edit_cursor_ctrl_pkg.sv
// Shared constants and state type for the time-edit cursor controller.
package edit_cursor_ctrl_pkg;

  localparam logic [3:0] MODE_IDLE   = 4'd0;
  localparam logic [3:0] MODE_EDIT   = 4'd1;
  localparam logic [3:0] MODE_COMMIT = 4'd2;

  localparam int unsigned NIBBLES    = 21;
  localparam int unsigned CURSOR_MAX = 20;

  // State encoding doubles as the externally visible mode value.
  typedef enum logic [3:0] {
    StIdle   = MODE_IDLE,
    StEdit   = MODE_EDIT,
    StCommit = MODE_COMMIT
  } state_e;

endpackage

// File: rtl/bcd_step.sv
// Single BCD digit step: up wraps 9->0, down wraps 0->9; non-decimal inputs snap to 0 (up) or 9 (down).
module bcd_step (
  input  logic [3:0] nibble_i,
  input  logic       up_i,
  output logic [3:0] nibble_o
);

  always_comb begin
    nibble_o = nibble_i;
    if (up_i) begin
      nibble_o = (nibble_i >= 4'd9) ? 4'd0 : nibble_i + 4'd1;
    end else begin
      nibble_o = ((nibble_i == 4'd0) || (nibble_i > 4'd9)) ? 4'd9 : nibble_i - 4'd1;
    end
  end

endmodule

// File: rtl/edit_cursor_ctrl.sv
// Time-string editor: enter starts an edit of a snapshot of time_in, arrows move/adjust digits,
// enter commits, and inactivity restores the snapshot.
module edit_cursor_ctrl
  import edit_cursor_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_enter,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic [83:0] time_in,
  output logic [83:0] tmp1,
  output logic [4:0]  count,
  output logic [3:0]  mode,
  output logic        commit,
  output logic        abort
);

  localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);
  localparam logic [4:0] CountMax = 5'(CURSOR_MAX);

  state_e              state_q, state_d;
  logic [83:0]         tmp1_q, tmp1_d;
  logic [83:0]         shadow_q, shadow_d;
  logic [4:0]          count_q, count_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                commit_q, commit_d;
  logic                abort_q, abort_d;

  logic                any_press;
  logic [6:0]          nib_base;
  logic [3:0]          cur_nib;
  logic [3:0]          step_nib;

  assign any_press = btn_enter | btn_left | btn_right | btn_up | btn_down;
  assign nib_base  = {count_q, 2'b00};
  assign cur_nib   = tmp1_q[nib_base +: 4];

  // Up outranks down, so when down acts btn_up is necessarily low.
  bcd_step u_bcd_step (
    .nibble_i (cur_nib),
    .up_i     (btn_up),
    .nibble_o (step_nib)
  );

  always_comb begin
    state_d  = state_q;
    tmp1_d   = tmp1_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    timer_d  = timer_q;
    commit_d = 1'b0;
    abort_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        tmp1_d  = time_in;
        count_d = CountMax;
        timer_d = '0;
        if (btn_enter) begin
          state_d  = StEdit;
          shadow_d = time_in;
        end
      end
      StEdit: begin
        if (any_press) begin
          timer_d = '0;
          if (btn_enter) begin
            state_d  = StCommit;
            commit_d = 1'b1;
          end else if (btn_left) begin
            if (count_q < CountMax) count_d = count_q + 5'd1;
          end else if (btn_right) begin
            if (count_q != 5'd0) count_d = count_q - 5'd1;
          end else begin
            tmp1_d[nib_base +: 4] = step_nib;
          end
        end else if (timer_q == TimerLast) begin
          tmp1_d  = shadow_q;
          abort_d = 1'b1;
          count_d = CountMax;
          timer_d = '0;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StCommit: begin
        state_d = StIdle;
        count_d = CountMax;
      end
      default: begin
        state_d = StIdle;
        count_d = CountMax;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      tmp1_q   <= '0;
      shadow_q <= '0;
      count_q  <= CountMax;
      timer_q  <= '0;
      commit_q <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmp1_q   <= tmp1_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      commit_q <= commit_d;
      abort_q  <= abort_d;
    end
  end

  assign tmp1   = tmp1_q;
  assign count  = count_q;
  assign mode   = state_q;
  assign commit = commit_q;
  assign abort  = abort_q;

endmodule
